// File: rtl/dbus_ctrl_if.sv
// Request/response bus between a load/store master and dbus_ctrl.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; all req_* fields
// are sampled on that edge. rsp_valid is a single-cycle strobe with no back-pressure, and rsp_err
// and rsp_rdata are meaningful only while it is high. busy and exc_status are status outputs.
interface dbus_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  exc_status;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, exc_status
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, exc_status
    );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller: byte/half/word access to a local RAM and a small control-register window.
// Define DBC_SIGN_EXT_EN to make signed byte/half loads sign-extend; otherwise every load zero-extends.
module dbus_ctrl #(
    parameter int unsigned RAM_WORDS   = 1024,
    parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
    parameter logic [31:0] REG_BASE    = 32'h0000_0F00,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    dbus_ctrl_if.slave       bus,
    output logic [1:0]       dbg_state_o
);
    localparam int          AW      = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;
    localparam logic [32:0] REG_END = {1'b0, REG_BASE} + 33'd256;
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        req_ready_q, busy_q, rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  exc_q;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [RAM_WORDS];

    // In IDLE the live request is decoded; in WAIT the captured one is.
    logic        in_idle, cur_we, cur_uns;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;

    assign in_idle   = (state_q == IDLE);
    assign cur_we    = in_idle ? bus.req_we       : we_q;
    assign cur_uns   = in_idle ? bus.req_unsigned : uns_q;
    assign cur_size  = in_idle ? bus.req_size     : size_q;
    assign cur_addr  = in_idle ? bus.req_addr     : addr_q;
    assign cur_wdata = in_idle ? bus.req_wdata    : wdata_q;

    logic misaligned, in_ram, in_reg, fault, accept, go_resp, ram_wr;
    assign misaligned = (cur_size == 2'b11)
                     || (cur_size == 2'b01 && cur_addr[0])
                     || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
    assign in_ram = ({1'b0, cur_addr} >= {1'b0, RAM_BASE}) && ({1'b0, cur_addr} < RAM_END);
    assign in_reg = ({1'b0, cur_addr} >= {1'b0, REG_BASE}) && ({1'b0, cur_addr} < REG_END);
    assign fault  = misaligned || !(in_ram || in_reg);
    assign accept = in_idle && bus.req_valid;
    assign go_resp = (accept && (fault || in_reg || WS == 4'd0))
                  || (state_q == WAIT && wait_cnt_q == 4'd1);
    assign ram_wr = go_resp && !rst && !fault && in_ram && cur_we;

    logic [AW-1:0] ram_idx;
    logic [7:0]    reg_off;
    assign ram_idx = AW'((cur_addr - RAM_BASE) >> 2);
    assign reg_off = 8'(cur_addr - REG_BASE);

    // Store data replicated across lanes; the byte enables pick the lanes that change.
    logic [3:0]  be;
    logic [31:0] wlanes;
    always_comb begin
        be     = 4'b1111;
        wlanes = cur_wdata;
        case (cur_size)
            2'b00: begin
                be     = 4'b0001 << cur_addr[1:0];
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be     = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    logic [31:0] reg_word, src_word, shifted, load_data;
    logic        sext;
    always_comb begin
        case (reg_off[7:2])
            6'd0:    reg_word = {30'b0, exc_q};
            6'd1:    reg_word = 32'h0000_0002;
            default: reg_word = 32'h0;
        endcase
        src_word = in_ram ? mem[ram_idx] : reg_word;
        shifted  = src_word >> {cur_addr[1:0], 3'b000};
`ifdef DBC_SIGN_EXT_EN
        sext = !cur_uns;
`else
        sext = 1'b0;
`endif
        case (cur_size)
            2'b00:   load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: load_data = src_word;
        endcase
    end

`ifndef DBC_SIGN_EXT_EN
    logic unused_uns;
    assign unused_uns = cur_uns;
`endif

    // Only a faulted request sets a bit and only a legal register store clears one,
    // so the two never land on the same edge; the OR order still lets set win.
    logic [1:0] exc_set, exc_clr;
    assign exc_set = (go_resp && fault) ? (misaligned ? 2'b01 : 2'b10) : 2'b00;
    assign exc_clr = (go_resp && !fault && in_reg && cur_we && reg_off[7:2] == 6'd0)
                   ? (wlanes[1:0] & {2{be[0]}}) : 2'b00;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[ram_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            exc_q       <= 2'b00;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            exc_q       <= (exc_q & ~exc_clr) | exc_set;
            if (go_resp) begin
                state_q     <= RESP;
                wait_cnt_q  <= 4'd0;
                req_ready_q <= 1'b0;
                busy_q      <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= fault;
                rsp_rdata_q <= (fault || cur_we) ? 32'h0 : load_data;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            state_q     <= WAIT;
                            wait_cnt_q  <= WS;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    WAIT: wait_cnt_q <= wait_cnt_q - 4'd1;
                    RESP: begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = busy_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.exc_status = exc_q;
    assign dbg_state_o    = state_q;
endmodule
